// File: rtl/muldiv_s4.sv
// RV32M execute-stage multiply/divide: 32-iteration shift-add multiplier / restoring divider.
// Latency: 34 cycles from the accept cycle to done; divide special cases take 1 edge to done.
// Backpressure: stall is combinational and holds the upstream latch/PC until the result is written.
module muldiv_s4 #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [4:0]       rd_q;
    logic             sign_a, sign_b;
    // mag_b is the addend for multiply and the divisor for divide;
    // acc_lo starts as |op_a| (multiplier bits / dividend bits), acc_hi is the running high half / remainder.
    logic [XLEN-1:0]  mag_b, acc_hi, acc_lo;

    logic             accept, is_div, a_signed, b_signed, sa_in, sb_in;
    logic             div_zero, div_ovf, spec_hit;
    logic [XLEN-1:0]  a_mag_in, b_mag_in, spec_res;

    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        sa_in    = a_signed & op_a[XLEN-1];
        sb_in    = b_signed & op_b[XLEN-1];
        a_mag_in = sa_in ? -op_a : op_a;
        b_mag_in = sb_in ? -op_b : op_b;
        div_zero = is_div & (op_b == '0);
        div_ovf  = is_div & ~funct3[0] & (op_a == INT_MIN) & (op_b == '1);
        spec_hit = div_zero | div_ovf;
        if (div_zero) begin
            spec_res = funct3[1] ? op_a : '1;
        end else begin
            spec_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = (state == IDLE) & start & ~flush;
        stall     = accept | (state == CALC) | (state == FIX);
        case (state)
            IDLE: if (accept) state_nxt = spec_hit ? DONE : CALC;
            CALC: if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    logic [XLEN:0]     mul_sum, div_rs, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_rs   = {acc_hi, acc_lo[XLEN-1]};
        div_diff = div_rs - {1'b0, mag_b};
        // Partial remainder is always below 2*divisor, so bit XLEN set means it went negative.
        div_ge   = ~div_diff[XLEN];

        prod     = {acc_hi, acc_lo};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        quot_fix = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix  = sign_a ? -acc_hi : acc_hi;

        case (op_q)
            3'b000:         fix_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fix_res = quot_fix;
            3'b110, 3'b111: fix_res = rem_fix;
            default:        fix_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            done <= (state_nxt == DONE);
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            op_q   <= funct3;
                            rd_q   <= rd_in;
                            sign_a <= sa_in;
                            sign_b <= sb_in;
                            mag_b  <= b_mag_in;
                            acc_hi <= '0;
                            acc_lo <= a_mag_in;
                            cnt    <= '0;
                            if (spec_hit) begin
                                result <= spec_res;
                                rd_out <= rd_in;
                            end
                        end
                    end
                    CALC: begin
                        cnt <= cnt + 1'b1;
                        if (op_q[2]) begin
                            acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                        end else begin
                            acc_hi <= mul_sum[XLEN:1];
                            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                        end
                    end
                    FIX: begin
                        result <= fix_res;
                        rd_out <= rd_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_s4.sv
// Directed bench for muldiv_s4 with an arithmetic reference model checked every cycle.
module tb_muldiv_s4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        flush  = 1'b0;
    logic        start  = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a   = 32'h0;
    logic [31:0] op_b   = 32'h0;
    logic [4:0]  rd_in  = 5'd0;
    logic        stall, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    muldiv_s4 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RV32M semantics in plain arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        int        ia, ib;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = int'(a);
        ib = int'(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Timing model: m_rem counts edges left until the done cycle; m_done marks the done cycle.
    int          m_rem  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_pend = 32'h0;
    logic [4:0]  m_rd   = 5'd0;
    logic [4:0]  m_prd  = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_res  <= 32'h0;
            m_rd   <= 5'd0;
        end else if (flush) begin
            m_rem  <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
                m_rd   <= m_prd;
            end
        end else if (start) begin
            if (is_fast(funct3, op_a, op_b)) begin
                m_done <= 1'b1;
                m_res  <= ref_op(funct3, op_a, op_b);
                m_rd   <= rd_in;
            end else begin
                m_rem  <= 33;
                m_pend <= ref_op(funct3, op_a, op_b);
                m_prd  <= rd_in;
            end
        end
    end

    always @(negedge clk) begin
        logic m_stall;
        m_stall = (m_rem > 0) || (m_rem == 0 && !m_done && start && !flush);
        check("model_done",   32'(done),   32'(m_done));
        check("model_stall",  32'(stall),  32'(m_stall));
        check("model_result", result,      m_res);
        check("model_rd_out", 32'(rd_out), 32'(m_rd));
    end

    // Issues one op and returns at the negedge of its done cycle.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp, input bit fast);
        int edges, stalls;
        bit got;
        edges = 0; stalls = 0; got = 0;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = r;
        @(negedge clk);
        if (stall) stalls++;
        @(posedge clk); #1;
        // Perturb upstream data after accept; the unit must not resample it.
        start = 1'b0; op_a = ~a; op_b = ~b; rd_in = ~r;
        while (!got && edges < 60) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                if (stall) stalls++;
                @(posedge clk); #1;
                edges++;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'(r));
        check({tag, "_edges"}, 32'(edges), fast ? 32'd0 : 32'd33);
        check({tag, "_stall_cycles"}, 32'(stalls), fast ? 32'd1 : 32'd34);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp, input bit fast);
        do_op(tag, f, a, b, r, exp, fast);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic expect_no_done(input string tag, input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int t0, t1;
        bit got;

        repeat (2) @(posedge clk);
        #1;
        check("rst_done",   32'(done),   32'd0);
        check("rst_stall",  32'(stall),  32'd0);
        check("rst_result", result,      32'h0);
        check("rst_rd",     32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 0);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 0);

        run_op("div",  3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 0);
        run_op("rem",  3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 0);
        run_op("divu", 3'd5, 32'd100,      32'd7, 5'd7, 32'd14,       0);
        run_op("remu", 3'd7, 32'd100,      32'd7, 5'd8, 32'd2,        0);

        // Flush on the 10th CALC edge: result/rd_out keep REMU's values.
        start = 1'b1; funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; rd_in = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_stall",  32'(stall),  32'd0);
        check("flush_result", result,      32'd2);
        check("flush_rd",     32'(rd_out), 32'd8);
        expect_no_done("flush_no_done", 40);
        @(posedge clk); #1;

        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd21;
        @(negedge clk);
        check("flush_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        expect_no_done("flush_start_no_done", 40);
        @(posedge clk); #1;

        run_op("div_by0",  3'd4, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1);
        run_op("remu_by0", 3'd7, 32'd5,        32'd0,        5'd10, 32'd5,        1);
        run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1);
        run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0,        1);

        // Asynchronous reset in the middle of CALC.
        start = 1'b1; funct3 = 3'd0; op_a = 32'h1234; op_b = 32'h5678; rd_in = 5'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_stall",  32'(stall),  32'd0);
        check("midrst_result", result,      32'h0);
        check("midrst_rd",     32'(rd_out), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        expect_no_done("midrst_no_done", 3);
        @(posedge clk); #1;
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 0);

        // Back-to-back: next op's start is presented during DONE and must wait one cycle.
        do_op("b2b_divu", 3'd5, 32'd9, 32'd3, 5'd15, 32'd3, 0);
        t0 = cyc;
        #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd16;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        t1 = cyc;
        check("b2b_done_seen", 32'(got), 32'd1);
        check("b2b_mul_result", result, 32'h1E);
        check("b2b_mul_rd", 32'(rd_out), 32'd16);
        check("b2b_gap_cycles", 32'(t1 - t0 - 1), 32'd34);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
